// File: rtl/mux_nx1_stream.sv
// -----------------------------------------------------------------------------
// mux_nx1_stream
//   N-to-1 streaming multiplexer with a single registered output stage.
//   Each input channel and the output use a valid/ready handshake.
//   The channel is picked either by an external select (MODE=0) or by a fair
//   round-robin arbiter (MODE=1).
//
// Handshake semantics (all ports): a word moves across an interface on a rising
//   clock edge where both valid and ready are high. A producer holds valid and
//   data stable until the word is taken. in_ready depends combinationally on
//   out_ready: a slot opens in the output register in the same cycle that the
//   consumer drains it.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_data       N*W  channel i data at [i*W +: W]
//   in_valid      N    channel i offers a word
//   in_ready      N    channel i word is taken this cycle (at most one bit set)
//   sel           SEL_W  selected channel, MODE=0 only
//   out_data      W    registered output word
//   out_valid     1    out_data holds a valid word
//   out_ready     1    consumer accepts out_data this cycle
//   out_chan      SEL_W  channel that supplied out_data
//   dbg_rr_ptr_o  SEL_W  round-robin pointer state (stays 0 when MODE=0)
// -----------------------------------------------------------------------------
module mux_nx1_stream #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_chan,
  output logic [SEL_W-1:0] dbg_rr_ptr_o
);

  logic [W-1:0]     out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic             load_en;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [2*N-1:0]   valid_dbl;
  logic [N-1:0]     valid_rot;
  logic [SEL_W:0]   rr_sum;
  logic [W-1:0]     sel_data;

  // Grant selection. In round-robin mode the valid vector is rotated so that
  // bit j corresponds to channel (rr_ptr + j) mod N; the lowest set bit of the
  // rotated vector is the first requester in search order.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    valid_dbl = {in_valid, in_valid};
    valid_rot = '0;
    rr_sum    = '0;
    if (MODE == 0) begin
      // A sel value >= N matches no channel, so it never grants.
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = SEL_W'(i);
        end
      end
    end else begin
      valid_rot = N'(valid_dbl >> rr_ptr_q);
      for (int j = 0; j < N; j++) begin
        if (!gnt_found && valid_rot[j]) begin
          gnt_found = 1'b1;
          rr_sum    = {1'b0, rr_ptr_q} + (SEL_W+1)'(j);
          if (rr_sum >= (SEL_W+1)'(N)) begin
            rr_sum = rr_sum - (SEL_W+1)'(N);
          end
          gnt_idx = rr_sum[SEL_W-1:0];
        end
      end
    end
  end

  // in_ready is forced low while reset is asserted, even though the empty
  // output register would otherwise make load_en high.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && gnt_found) begin
      in_ready = N'(1) << gnt_idx;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        sel_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = gnt_found;
      if (gnt_found) begin
        out_data_d = sel_data;
        out_chan_d = gnt_idx;
        if (MODE != 0) begin
          // Explicit wrap: N need not be a power of two.
          rr_ptr_d = (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_chan     = out_chan_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule
